nonce_dispatcher: RTL

- Issues candidate nonces to the hash core and consumes the comparator's verdict (`valid` / `bounty`) at the other end of the hash-to-comparator path.
- Keeps up to INFLIGHT nonces outstanding in an in-order tag FIFO and pairs each completed hash with its nonce.
- Latches the first winning nonce/hash pair, or reports that the range is exhausted.
- Sits between the top-level miner control and the hash core + comparador pair.

---
 rtl/miner_pkg.sv | 6 +
 rtl/nonce_dispatcher_if.sv | 14 +
 rtl/nonce_tag_fifo.sv | 39 +++
 rtl/nonce_dispatcher.sv | 85 ++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared widths and dispatcher FSM states for the miner datapath.
package miner_pkg;
  localparam int DEF_NONCE_W = 32;
  localparam int DEF_HASH_W = 24;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/nonce_dispatcher_if.sv
// nonce_dispatcher_if: dispatcher <-> hash core/comparator link.
interface nonce_dispatcher_if import miner_pkg::*; #(
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int HASH_W = DEF_HASH_W
);
  logic [NONCE_W-1:0] nonce;
  logic nonce_valid;
  logic nonce_ready;
  logic hash_done;
  logic valid;
  logic [HASH_W-1:0] bounty;
  modport master(output nonce, nonce_valid, input nonce_ready, hash_done, valid, bounty);
  modport slave(input nonce, nonce_valid, output nonce_ready, hash_done, valid, bounty);
endinterface

// File: rtl/nonce_tag_fifo.sv
// nonce_tag_fifo: in-order FIFO of outstanding nonces awaiting their hash result.
module nonce_tag_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: issues nonces to the hash core, pairs verdicts with their nonce,
// latches the first winner or flags an exhausted range.
module nonce_dispatcher import miner_pkg::*; #(
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int HASH_W = DEF_HASH_W,
  parameter int INFLIGHT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  nonce_dispatcher_if.master core,
  output logic busy,
  output logic found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [HASH_W-1:0] found_hash,
  output logic exhausted,
  output logic [NONCE_W-1:0] attempts,
  output logic proto_err
);
  localparam int CW = $clog2(INFLIGHT) + 1;
  state_t state, state_n;
  logic [NONCE_W-1:0] ctr, last_nonce, head;
  logic [CW-1:0] count;
  logic full, empty, push, pop, win, launch, drained;
  assign launch = start && (state == IDLE || state == DONE);
  assign core.nonce = ctr;
  assign core.nonce_valid = state == ISSUE && !full;
  assign push = core.nonce_valid && core.nonce_ready;
  assign pop = core.hash_done && !empty;
  assign win = pop && core.valid && !found;
  // DRAIN may finish on the very edge that pops the last entry
  assign drained = empty || (pop && count == CW'(1));
  assign busy = state == ISSUE || state == DRAIN;
  nonce_tag_fifo #(.WIDTH(NONCE_W), .DEPTH(INFLIGHT)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(ctr),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    state_n = launch ? ISSUE
            : (state == ISSUE && (win || (push && ctr == last_nonce))) ? DRAIN
            : (state == DRAIN && drained) ? DONE
            : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ctr <= '0;
      last_nonce <= '0;
      found <= 1'b0;
      found_nonce <= '0;
      found_hash <= '0;
      exhausted <= 1'b0;
      attempts <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      if (core.hash_done && empty) proto_err <= 1'b1;
      if (launch) begin
        ctr <= nonce_first;
        last_nonce <= nonce_last;
        found <= 1'b0;
        exhausted <= 1'b0;
        attempts <= '0;
      end else begin
        if (push && ctr != last_nonce) ctr <= ctr + 1'b1;
        if (pop && ~&attempts) attempts <= attempts + 1'b1;
        if (win) begin
          found <= 1'b1;
          found_nonce <= head;
          found_hash <= core.bounty;
        end
        if (state == DRAIN && drained && !found && !win) exhausted <= 1'b1;
      end
    end
  end
endmodule
